// File: rtl/mmio_bus_ctrl.sv
// Byte-wide CPU bus decoder: RAM pass-through, UART TX/RX byte FIFOs, cycle counter and halt flag.
// Read data returns one cycle after the address; rdy_in low freezes all state except RX capture.

module mmio_fifo #(
    parameter int DEPTH_BIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [7:0]           push_data,
    input  logic                 pop,
    output logic [7:0]           head,
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH_BIT:0]   count_next
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] ONE = 1;

    logic [7:0]         mem [DEPTH];
    logic [DEPTH_BIT:0] wr_ptr;
    logic [DEPTH_BIT:0] rd_ptr;
    logic [DEPTH_BIT:0] count;
    logic               do_push;
    logic               do_pop;

    // The extra pointer bit separates a full ring from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_BIT-1:0] == rd_ptr[DEPTH_BIT-1:0]) &&
                     (wr_ptr[DEPTH_BIT] != rd_ptr[DEPTH_BIT]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[DEPTH_BIT-1:0]];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + ONE;
        end else if (do_pop && !do_push) begin
            count_next = count - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_BIT-1:0]] <= push_data;
    end
endmodule

module mmio_bus_ctrl #(
    parameter int TX_DEPTH_BIT = 3,
    parameter int RX_DEPTH_BIT = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        ram_we,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        program_end
);
    localparam logic [TX_DEPTH_BIT:0] FULL_THRESH =
        (TX_DEPTH_BIT+1)'((1 << TX_DEPTH_BIT) - FULL_MARGIN);
    localparam logic [17:0] A_DATA = 18'h30000;
    localparam logic [17:0] A_CTL  = 18'h30004;

    logic [17:0]           addr;
    logic                  unused_addr_hi;
    logic                  io;
    logic                  wr_req;
    logic                  rd_req;
    logic                  hit_data;
    logic                  hit_ctl;
    logic                  tx_push;
    logic [7:0]            tx_push_data;
    logic                  tx_pop;
    logic                  tx_empty;
    logic [7:0]            tx_head;
    logic [TX_DEPTH_BIT:0] tx_cnt_next;
    logic                  unused_tx_full;
    logic                  rx_pop;
    logic                  rx_empty;
    logic [7:0]            rx_head;
    logic                  unused_rx_full;
    logic [RX_DEPTH_BIT:0] unused_rx_cnt;
    logic [31:0]           cycle_cnt;
    logic [31:0]           snapshot;
    logic                  resp_ram;
    logic                  resp_live;
    logic [7:0]            resp_byte;
    logic [7:0]            hold_byte;
    logic [7:0]            io_byte;

    assign addr           = mem_a[17:0];
    assign unused_addr_hi = ^mem_a[31:18];
    assign io             = (addr[17:16] == 2'b11);
    assign wr_req         = rdy_in & mem_wr;
    assign rd_req         = rdy_in & ~mem_wr;
    assign hit_data       = (addr == A_DATA);
    assign hit_ctl        = (addr == A_CTL);

    assign ram_we    = wr_req & ~io;
    assign ram_addr  = mem_a[16:0];
    assign ram_wdata = mem_dout;

    // A halt write also emits a 0x00 marker byte to the UART.
    assign tx_push      = wr_req & ((hit_data & (mem_dout != 8'h00)) | hit_ctl);
    assign tx_push_data = hit_ctl ? 8'h00 : mem_dout;
    assign tx_valid     = ~tx_empty;
    assign tx_data      = tx_empty ? 8'h00 : tx_head;
    assign tx_pop       = tx_valid & tx_ready & rdy_in;
    assign rx_pop       = rd_req & hit_data;

    mmio_fifo #(.DEPTH_BIT(TX_DEPTH_BIT)) u_tx_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (tx_push),
        .push_data  (tx_push_data),
        .pop        (tx_pop),
        .head       (tx_head),
        .empty      (tx_empty),
        .full       (unused_tx_full),
        .count_next (tx_cnt_next)
    );

    // The UART cannot stall, so RX capture ignores rdy_in.
    mmio_fifo #(.DEPTH_BIT(RX_DEPTH_BIT)) u_rx_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (rx_valid),
        .push_data  (rx_data),
        .pop        (rx_pop),
        .head       (rx_head),
        .empty      (rx_empty),
        .full       (unused_rx_full),
        .count_next (unused_rx_cnt)
    );

    always_comb begin
        io_byte = 8'h00;
        case (addr)
            A_DATA:   io_byte = rx_empty ? 8'h00 : rx_head;
            A_CTL:    io_byte = cycle_cnt[7:0];
            18'h30005: io_byte = snapshot[15:8];
            18'h30006: io_byte = snapshot[23:16];
            18'h30007: io_byte = snapshot[31:24];
            default:  io_byte = 8'h00;
        endcase
    end

    // After a frozen request cycle the previous byte is replayed from hold_byte.
    assign mem_din = resp_live ? (resp_ram ? ram_rdata : resp_byte) : hold_byte;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt      <= '0;
            snapshot       <= '0;
            resp_ram       <= 1'b1;
            resp_live      <= 1'b0;
            resp_byte      <= '0;
            hold_byte      <= '0;
            io_buffer_full <= 1'b0;
            program_end    <= 1'b0;
        end else begin
            resp_live <= rdy_in;
            hold_byte <= mem_din;
            if (rdy_in) begin
                cycle_cnt      <= cycle_cnt + 32'd1;
                resp_ram       <= ~io;
                resp_byte      <= io_byte;
                io_buffer_full <= (tx_cnt_next >= FULL_THRESH);
                if (rd_req && hit_ctl) snapshot    <= cycle_cnt;
                if (wr_req && hit_ctl) program_end <= 1'b1;
            end
        end
    end
endmodule
